// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in / serial-out transmitter.
// The state enum and bit-order selectors are used by piso_tx and its users.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int SHIFT_LSB_FIRST = 0;
  localparam int SHIFT_MSB_FIRST = 1;

endpackage

// File: rtl/piso_tx.sv
// Serializes SIZE-bit words onto a single bit stream with a one-word holding
// register, downstream hold, and a registered done pulse per completed word.
module piso_tx
  import piso_pkg::*;
#(
  parameter int SIZE      = 8,
  parameter int SHIFT_DIR = SHIFT_LSB_FIRST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] data_in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            hold,
  output logic            out,
  output logic            out_valid,
  output logic            done,
  output logic            busy
);

  localparam int            CW   = $clog2(SIZE);
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  state_t          r_state;
  logic [SIZE-1:0] r_shifter;
  logic [SIZE-1:0] r_hold_reg;
  logic            r_pending_valid;
  logic [CW-1:0]   r_bit_count;
  logic            r_done;

  state_t          w_state_nxt;
  logic [SIZE-1:0] w_shifter_nxt;
  logic [SIZE-1:0] w_hold_reg_nxt;
  logic            w_pending_nxt;
  logic [CW-1:0]   w_bit_count_nxt;
  logic            w_done_nxt;

  logic            w_accept;
  logic            w_word_end;
  logic [CW-1:0]   w_bit_idx;

  assign in_ready   = ~r_pending_valid;
  assign w_accept   = in_valid & in_ready;
  assign out_valid  = (r_state == SHIFT) & ~hold;
  assign w_word_end = out_valid & (r_bit_count == LAST);
  assign busy       = (r_state == SHIFT);
  assign done       = r_done;

  // The shifter is held still and indexed, so hold freezes out for free.
  assign w_bit_idx = (SHIFT_DIR == SHIFT_MSB_FIRST) ? (LAST - r_bit_count) : r_bit_count;
  assign out       = r_shifter[w_bit_idx];

  always_comb begin
    // NOTE: every next-value gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    w_state_nxt     = r_state;
    w_shifter_nxt   = r_shifter;
    w_hold_reg_nxt  = r_hold_reg;
    w_pending_nxt   = r_pending_valid;
    w_bit_count_nxt = r_bit_count;
    w_done_nxt      = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_shifter_nxt   = data_in;
          w_bit_count_nxt = '0;
          w_state_nxt     = SHIFT;
        end
      end

      SHIFT: begin
        if (w_word_end) begin
          w_done_nxt      = 1'b1;
          w_bit_count_nxt = '0;
          // in_ready is low while pending, so both branches cannot accept at once.
          if (r_pending_valid) begin
            w_shifter_nxt = r_hold_reg;
            w_pending_nxt = 1'b0;
          end else if (w_accept) begin
            w_shifter_nxt = data_in;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          if (out_valid) begin
            w_bit_count_nxt = r_bit_count + CW'(1);
          end
          if (w_accept) begin
            w_hold_reg_nxt = data_in;
            w_pending_nxt  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_shifter       <= '0;
      r_hold_reg      <= '0;
      r_pending_valid <= 1'b0;
      r_bit_count     <= '0;
      r_done          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      r_state         <= w_state_nxt;
      r_shifter       <= w_shifter_nxt;
      r_hold_reg      <= w_hold_reg_nxt;
      r_pending_valid <= w_pending_nxt;
      r_bit_count     <= w_bit_count_nxt;
      r_done          <= w_done_nxt;
    end
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL have parameter SIZE, default 8, giving the word width in bits; legal values are 2 or more.
REQ-002 The block SHALL have parameter SHIFT_DIR, default 0, where 0 sends LSB first and 1 sends MSB first.
REQ-003 Port clk: input, 1 bit, clock; every register is updated on the rising edge.
REQ-004 Port reset: input, 1 bit, asynchronous, active-high reset.
REQ-005 Port data_in: input, SIZE bits, parallel word to serialize.
REQ-006 Port in_valid: input, 1 bit, data_in is valid.
REQ-007 Port in_ready: output, 1 bit, block can accept a word.
REQ-008 Port hold: input, 1 bit, downstream stall; pauses shifting.
REQ-009 Port out: output, 1 bit, serial data bit currently presented.
REQ-010 Port out_valid: output, 1 bit, out is valid; drives the downstream deserializer enable.
REQ-011 Port done: output, 1 bit, one-cycle pulse after the last bit of a word is consumed.
REQ-012 Port busy: output, 1 bit, a word is being shifted.

Function
REQ-013 A word SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-014 in_ready SHALL equal NOT pending_valid, where pending_valid flags the one-word holding register.
REQ-015 The block SHALL have two states: IDLE and SHIFT; busy SHALL be 1 exactly when the state is SHIFT.
REQ-016 Acceptance in IDLE SHALL load the word into the shifter, clear bit_count and enter SHIFT; the first bit appears in the next cycle (1-cycle latency).
REQ-017 Acceptance in SHIFT, other than at a word-end edge, SHALL store the word in the holding register and set pending_valid.
REQ-018 out SHALL present shifter bit bit_count when SHIFT_DIR=0, and bit SIZE-1-bit_count when SHIFT_DIR=1.
REQ-019 out_valid SHALL equal (state==SHIFT) AND NOT hold, combinationally.
REQ-020 Each edge with out_valid=1 SHALL consume the current bit; bit_count SHALL be $clog2(SIZE) bits wide.
REQ-021 bit_count SHALL increment by 1 per consumed bit; the word ends when the bit at bit_count==SIZE-1 is consumed.
REQ-022 While hold=1, bit_count, the shifter and out SHALL stay unchanged.
REQ-023 Word-end edge with pending_valid=1: the holding register SHALL load into the shifter, pending_valid SHALL clear, bit_count SHALL reset to 0, and the state SHALL stay SHIFT.
REQ-024 Word-end edge with pending_valid=0 and an accepted word: data_in SHALL load directly into the shifter (bypass), and the state SHALL stay SHIFT.
REQ-025 Word-end edge with no pending word and no accepted word: the state SHALL return to IDLE.
REQ-026 As a consequence of REQ-023 and REQ-024, a continuous word stream SHALL produce gap-free out_valid.
REQ-027 done SHALL be a registered pulse, high for exactly the one cycle after each word-end edge.
REQ-028 An in_valid that arrives during hold SHALL still be accepted into the holding register when in_ready=1.

Reset
REQ-029 On reset=1, the block SHALL asynchronously return to IDLE with bit_count=0, shifter=0, pending_valid=0, done=0 and busy=0, giving out=0, out_valid=0 and in_ready=1.
REQ-030 Reset during shifting SHALL abort the current word and discard any pending word, with no done pulse.

Structure
REQ-031 Package piso_pkg SHALL hold the state enum type (IDLE, SHIFT) and the constants SHIFT_LSB_FIRST=0 and SHIFT_MSB_FIRST=1.
REQ-032 The block SHALL have no sub-module; the holding register and shifter SHALL be implemented inline in piso_tx.

Verification (SIZE=8)
REQ-033 Scenario: reset, then load 0x0F with SHIFT_DIR=0 -> out = 1,1,1,1,0,0,0,0 over 8 out_valid cycles; done high in cycle 9; busy low afterwards.
REQ-034 Scenario: SHIFT_DIR=1, load 0x0F -> out = 0,0,0,0,1,1,1,1.
REQ-035 Scenario: accept 0x0F, then offer 0xF0 at cycle 2 -> 0xF0 goes to the holding register; in_ready low until the first word ends; 16 contiguous out_valid cycles; two done pulses 8 cycles apart.
REQ-036 Scenario: hold=1 for 3 cycles at bit 3 -> out_valid low and out stable during the hold; the word completes in 11 cycles; the bit order is unchanged.
REQ-037 Scenario: reset pulse at bit 4 with a pending word -> the next cycle shows out_valid=0, busy=0, done=0 and in_ready=1; no further bits are emitted.
REQ-038 Scenario: loopback into the downstream sipo with matching SIZE and SHIFT_DIR, 100 random back-to-back words -> each sipo word equals the corresponding data_in, and the done pulses of both blocks align.
